// File: rtl/ctrl_pkg.sv
// Shared opcode map, WD3 source codes, sequencer states and the control strobe bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_MASK_ALU = 6'b100000;
  localparam logic [5:0] OP_ALU      = 6'b000000;
  localparam logic [5:0] OP_MASK_GRP = 6'b111100;
  localparam logic [5:0] OP_LI       = 6'b100000;
  localparam logic [5:0] OP_IN       = 6'b100100;
  localparam logic [5:0] OP_OUT      = 6'b101000;
  localparam logic [5:0] OP_MASK_STK = 6'b111101;
  localparam logic [5:0] OP_PUSH     = 6'b101100;
  localparam logic [5:0] OP_POP      = 6'b101101;
  localparam logic [5:0] OP_J        = 6'b110000;
  localparam logic [5:0] OP_JZ       = 6'b110001;
  localparam logic [5:0] OP_JNZ      = 6'b110010;
  localparam logic [5:0] OP_JAL      = 6'b110011;
  localparam logic [5:0] OP_RET      = 6'b110100;
  localparam logic [5:0] OP_HALT     = 6'b111111;

  localparam logic [1:0] SEL_ALU   = 2'b00;
  localparam logic [1:0] SEL_PORT  = 2'b01;
  localparam logic [1:0] SEL_STACK = 2'b10;
  localparam logic [1:0] SEL_INM   = 2'b11;

  typedef enum logic [1:0] {START, RUN, IO_WAIT, HALT} state_t;

  typedef struct packed {
    logic       s_inc;
    logic       s_jalret;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
    logic [1:0] sel_inputs;
    logic       s_we_port;
    logic       s_we_stack;
    logic       s_we_stack_data;
    logic       s_pushpop;
  } ctrl_t;

  // Quiescent strobe set: no writes, PC advances sequentially.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c       = '0;
    c.s_inc = 1'b1;
    return c;
  endfunction

  function automatic logic op_match(input logic [5:0] op, input logic [5:0] mask,
                                    input logic [5:0] val);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure opcode decode: raw strobe set before any sequencing or I/O gating.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       is_io,
  output logic       is_halt
);

  always_comb begin
    ctrl    = ctrl_idle();
    is_io   = 1'b0;
    is_halt = 1'b0;
    if (op_match(opcode, OP_MASK_ALU, OP_ALU)) begin
      ctrl.we3        = 1'b1;
      ctrl.wez        = 1'b1;
      ctrl.op_alu     = opcode[4:2];
      ctrl.sel_inputs = SEL_ALU;
    end else if (op_match(opcode, OP_MASK_GRP, OP_LI)) begin
      ctrl.we3        = 1'b1;
      ctrl.sel_inputs = SEL_INM;
    end else if (op_match(opcode, OP_MASK_GRP, OP_IN)) begin
      ctrl.we3        = 1'b1;
      ctrl.sel_inputs = SEL_PORT;
      is_io           = 1'b1;
    end else if (op_match(opcode, OP_MASK_GRP, OP_OUT)) begin
      ctrl.s_we_port = 1'b1;
      is_io          = 1'b1;
    end else if (op_match(opcode, OP_MASK_STK, OP_PUSH)) begin
      ctrl.s_we_stack_data = 1'b1;
      ctrl.s_pushpop       = 1'b1;
    end else if (op_match(opcode, OP_MASK_STK, OP_POP)) begin
      ctrl.s_we_stack_data = 1'b1;
      ctrl.s_pushpop       = 1'b0;
      ctrl.we3             = 1'b1;
      ctrl.sel_inputs      = SEL_STACK;
    end else begin
      case (opcode)
        OP_J:    ctrl.s_inc = 1'b0;
        OP_JZ:   ctrl.s_inc = !z;
        OP_JNZ:  ctrl.s_inc = z;
        OP_JAL: begin
          ctrl.s_inc      = 1'b0;
          ctrl.s_we_stack = 1'b1;
        end
        OP_RET: begin
          ctrl.s_inc    = 1'b0;
          ctrl.s_jalret = 1'b1;
        end
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Sequencer around the opcode decode: start-up bubble, I/O wait states with timeout, HALT/wake.
// state   | meaning
// START   | reset bubble, PC held, no strobes
// RUN     | normal decode, one instruction per cycle
// IO_WAIT | IN/OUT stalled on io_ready, bounded by IO_TIMEOUT
// HALT    | stopped until wake; wake cycle advances PC past HALT
module control_unit
  import ctrl_pkg::*;
#(
  parameter int IO_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       io_ready,
  input  logic       wake,
  output logic       s_inc,
  output logic       s_jalret,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu,
  output logic [1:0] sel_inputs,
  output logic       s_we_port,
  output logic       s_we_stack,
  output logic       s_we_stack_data,
  output logic       s_pushpop,
  output logic       io_req,
  output logic       pc_hold,
  output logic       halted,
  output logic       io_err
);

  localparam int CW = $clog2(IO_TIMEOUT);

  state_t        state;
  logic [CW-1:0] cnt;
  ctrl_t         raw;
  ctrl_t         c;
  logic          is_io;
  logic          is_halt;
  logic          tmo;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .z       (z),
    .ctrl    (raw),
    .is_io   (is_io),
    .is_halt (is_halt)
  );

  assign tmo = (cnt == CW'(IO_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= START;
      cnt    <= '0;
      io_err <= 1'b0;
    end else begin
      unique case (state)
        START: state <= RUN;
        RUN: begin
          if (is_halt) begin
            state <= HALT;
          end else if (is_io && !io_ready) begin
            state <= IO_WAIT;
            cnt   <= '0;
          end
        end
        IO_WAIT: begin
          cnt <= cnt + CW'(1);
          // A late io_ready in the last allowed cycle still counts as success.
          if (io_ready) begin
            state <= RUN;
          end else if (tmo) begin
            state  <= RUN;
            io_err <= 1'b1;
          end
        end
        HALT: if (wake) state <= RUN;
      endcase
    end
  end

  always_comb begin
    c       = ctrl_idle();
    io_req  = 1'b0;
    pc_hold = 1'b1;
    halted  = 1'b0;
    unique case (state)
      START: ;
      RUN: begin
        if (is_halt) begin
          pc_hold = 1'b1;
        end else if (is_io && !io_ready) begin
          io_req = 1'b1;
        end else begin
          c       = raw;
          pc_hold = 1'b0;
          io_req  = is_io;
        end
      end
      IO_WAIT: begin
        io_req = 1'b1;
        if (io_ready) begin
          c       = raw;
          pc_hold = 1'b0;
        end else if (tmo) begin
          pc_hold = 1'b0;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (wake) pc_hold = 1'b0;
      end
    endcase
  end

  assign s_inc           = c.s_inc;
  assign s_jalret        = c.s_jalret;
  assign we3             = c.we3;
  assign wez             = c.wez;
  assign op_alu          = c.op_alu;
  assign sel_inputs      = c.sel_inputs;
  assign s_we_port       = c.s_we_port;
  assign s_we_stack      = c.s_we_stack;
  assign s_we_stack_data = c.s_we_stack_data;
  assign s_pushpop       = c.s_pushpop;

endmodule
